// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush/bubble control, memory-wait FSM, timeout flag, perf counters.
// Define FORWARDING_EN when a forwarding unit is present (hazard becomes load-use only).
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1_id,
  input  logic [4:0]       src2_id,
  input  logic             two_src_id,
  input  logic [4:0]       dst_exe,
  input  logic             wb_en_exe,
  input  logic             mem_r_en_exe,
  input  logic [4:0]       dst_mem,
  input  logic             wb_en_mem,
  input  logic             branch_taken_exe,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             stall_all,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  localparam logic [11:0] Timeout = 12'(MEM_TIMEOUT);

  state_e           state_q;
  logic [11:0]      wcnt_q;
  logic [11:0]      wcnt_inc;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic hit_exe;
  logic hazard;

  // Register 0 is hard-wired, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic en);
    return en && (dst != 5'd0) && (src == dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign hit_exe = reg_match(src1_id, dst_exe, wb_en_exe) |
                   (two_src_id & reg_match(src2_id, dst_exe, wb_en_exe));

`ifdef FORWARDING_EN
  logic unused_mem_stage;
  assign unused_mem_stage = ^{dst_mem, wb_en_mem};
  assign hazard = mem_r_en_exe & hit_exe;
`else
  logic hit_mem;
  logic unused_load_flag;
  assign unused_load_flag = mem_r_en_exe;
  assign hit_mem = reg_match(src1_id, dst_mem, wb_en_mem) |
                   (two_src_id & reg_match(src2_id, dst_mem, wb_en_mem));
  assign hazard  = hit_exe | hit_mem;
`endif

  always_comb begin
    stall_all     = 1'b0;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    if (!rst) begin
      stall_all = !mem_ready && ((state_q == StRun && mem_req) || state_q == StMemWait);
      if (!stall_all) begin
        if (branch_taken_exe) begin
          // The ID instruction is squashed, so its hazard is irrelevant.
          flush_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
        end else if (hazard) begin
          freeze_pc     = 1'b1;
          freeze_if_id  = 1'b1;
          bubble_id_exe = 1'b1;
        end
      end
    end
  end

  assign wcnt_inc = (&wcnt_q) ? wcnt_q : wcnt_q + 12'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      wcnt_q       <= '0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_req && !mem_ready) begin
            state_q <= StMemWait;
            wcnt_q  <= '0;
          end
        end
        StMemWait: begin
          if (mem_ready) begin
            state_q <= StRun;
          end else begin
            wcnt_q <= wcnt_inc;
            // Flag only; the access is never aborted.
            if (wcnt_inc >= Timeout) mem_err_q <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
      if (stall_all)   stall_cnt_q  <= sat_inc(stall_cnt_q);
      if (freeze_pc)   bubble_cnt_q <= sat_inc(bubble_cnt_q);
      if (flush_if_id) flush_cnt_q  <= sat_inc(flush_cnt_q);
    end
  end

  assign mem_err    = mem_err_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CW = 5;
  localparam int TO = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] src1_id, src2_id, dst_exe, dst_mem;
  logic two_src_id, wb_en_exe, mem_r_en_exe, wb_en_mem;
  logic branch_taken_exe, mem_req, mem_ready;
  logic freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, stall_all, mem_err;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_stall, m_bubble, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .src1_id(src1_id), .src2_id(src2_id), .two_src_id(two_src_id),
    .dst_exe(dst_exe), .wb_en_exe(wb_en_exe), .mem_r_en_exe(mem_r_en_exe),
    .dst_mem(dst_mem), .wb_en_mem(wb_en_mem),
    .branch_taken_exe(branch_taken_exe), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .bubble_id_exe(bubble_id_exe), .stall_all(stall_all), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CntMax) ? CntMax : v;
  endfunction

  // A source is a dependency on any producer that writes the same nonzero register.
  function automatic bit model_hazard();
    logic [4:0] used[$];
    used.push_back(src1_id);
    if (two_src_id) used.push_back(src2_id);
    foreach (used[i]) begin
      if (used[i] != 5'd0) begin
`ifdef FORWARDING_EN
        if (wb_en_exe && mem_r_en_exe && used[i] == dst_exe) return 1'b1;
`else
        if (wb_en_exe && used[i] == dst_exe) return 1'b1;
        if (wb_en_mem && used[i] == dst_mem) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    src1_id = 0; src2_id = 0; two_src_id = 0; dst_exe = 0; wb_en_exe = 0;
    mem_r_en_exe = 0; dst_mem = 0; wb_en_mem = 0; branch_taken_exe = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    bit e_stall, e_br, e_haz;
    #1;
    e_stall = !rst && !mem_ready && (m_wait || mem_req);
    e_br    = !rst && !e_stall && branch_taken_exe;
    e_haz   = !rst && !e_stall && !branch_taken_exe && model_hazard();
    check("stall_all", stall_all, e_stall);
    check("freeze_pc", freeze_pc, e_haz);
    check("freeze_if_id", freeze_if_id, e_haz);
    check("flush_if_id", flush_if_id, e_br);
    check("bubble_id_exe", bubble_id_exe, e_br || e_haz);
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
    end else begin
      if (!m_wait) begin
        if (mem_req && !mem_ready) begin
          m_wait = 1;
          m_wcnt = 0;
        end
      end else if (mem_ready) begin
        m_wait = 0;
      end else begin
        if (m_wcnt < 4095) m_wcnt++;
        if (m_wcnt >= TO) m_err = 1;
      end
      m_stall  = sat(m_stall + int'(e_stall));
      m_bubble = sat(m_bubble + int'(e_haz));
      m_flush  = sat(m_flush + int'(e_br));
    end
    #1;
    check("mem_err", mem_err, m_err);
    check("stall_cnt", stall_cnt, m_stall);
    check("bubble_cnt", bubble_cnt, m_bubble);
    check("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    mem_req = 1; branch_taken_exe = 1; src1_id = 3; dst_exe = 3; wb_en_exe = 1;
    do_reset();
    check("reset_stall_cnt", stall_cnt, 0);

    // Load-use on src1
    wb_en_exe = 1; mem_r_en_exe = 1; dst_exe = 5; src1_id = 5;
    cycle();
    check("lu_bubble_cnt", bubble_cnt, 1);
    clear_inputs(); src1_id = 5; dst_mem = 5; wb_en_mem = 1;
    cycle();
    clear_inputs(); cycle();

    // Register zero never matches
    do_reset();
    wb_en_exe = 1; mem_r_en_exe = 1; dst_exe = 0; src1_id = 0;
    cycle();
    check("r0_bubble_cnt", bubble_cnt, 0);

    // ALU dependency through src2, then with src2 unused
    for (int t = 0; t < 2; t++) begin
      do_reset();
      two_src_id = (t == 0);
      src2_id = 7; wb_en_exe = 1; dst_exe = 7;
      cycle();
      wb_en_exe = 0; dst_exe = 0; wb_en_mem = 1; dst_mem = 7;
      cycle();
      wb_en_mem = 0; dst_mem = 0;
      cycle();
`ifdef FORWARDING_EN
      check("alu_bubbles", bubble_cnt, 0);
`else
      check("alu_bubbles", bubble_cnt, (t == 0) ? 2 : 0);
`endif
    end

    // Branch overrides a load-use hazard
    do_reset();
    branch_taken_exe = 1; wb_en_exe = 1; mem_r_en_exe = 1; dst_exe = 9; src1_id = 9;
    cycle();
    check("br_flush_cnt", flush_cnt, 1);
    check("br_bubble_cnt", bubble_cnt, 0);

    // Memory wait with a pending branch
    do_reset();
    mem_req = 1; mem_ready = 0; branch_taken_exe = 1;
    repeat (3) cycle();
    check("mw_flush_during", flush_cnt, 0);
    mem_ready = 1;
    cycle();
    check("mw_stall_cnt", stall_cnt, 3);
    check("mw_flush_after", flush_cnt, 1);
    clear_inputs(); cycle();

    // Timeout: sticky until reset
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (10) cycle();
    check("to_err_set", mem_err, 1);
    mem_ready = 1; cycle();
    clear_inputs(); repeat (3) cycle();
    check("to_err_sticky", mem_err, 1);
    do_reset();
    check("to_err_clear", mem_err, 0);

    // Reset in the middle of a wait
    mem_req = 1; mem_ready = 0;
    repeat (3) cycle();
    rst = 1; branch_taken_exe = 1; wb_en_exe = 1; mem_r_en_exe = 1; dst_exe = 4; src1_id = 4;
    cycle();
    rst = 0; clear_inputs();
    cycle();
    check("rmw_stall_cnt", stall_cnt, 0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst              = ($urandom_range(0, 299) == 0);
      src1_id          = 5'($urandom_range(0, 3));
      src2_id          = 5'($urandom_range(0, 3));
      two_src_id       = 1'($urandom_range(0, 1));
      dst_exe          = 5'($urandom_range(0, 3));
      wb_en_exe        = 1'($urandom_range(0, 1));
      mem_r_en_exe     = 1'($urandom_range(0, 1));
      dst_mem          = 5'($urandom_range(0, 3));
      wb_en_mem        = 1'($urandom_range(0, 1));
      branch_taken_exe = ($urandom_range(0, 99) < 15);
      mem_req          = ($urandom_range(0, 99) < 30);
      mem_ready        = ($urandom_range(0, 99) < 40);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core (IF/ID/EXE/MEM/WB). It generates the freeze, flush and bubble controls for the pipeline registers from three sources:
- register hazards in ID;
- taken branches resolved in EXE;
- a multi-cycle memory handshake in MEM.

It sits beside the forwarding logic and decides when forwarding is insufficient. It also keeps saturating performance counters and a memory-timeout error flag.

Parameters:
CNT_W, 16, width of each performance counter.
MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_err sets; legal range 1 to 2^12-1.

Ports:
clk  in  1  pipeline clock.
rst  in  1  synchronous, active-high reset.
src1_id  in  5  ID-stage source register 1.
src2_id  in  5  ID-stage source register 2.
two_src_id  in  1  ID instruction reads src2_id (R-type or store).
dst_exe  in  5  destination register of the EXE-stage instruction.
wb_en_exe  in  1  EXE-stage instruction writes back.
mem_r_en_exe  in  1  EXE-stage instruction is a load.
dst_mem  in  5  destination register of the MEM-stage instruction.
wb_en_mem  in  1  MEM-stage instruction writes back.
branch_taken_exe  in  1  EXE-stage branch or jump taken.
mem_req  in  1  MEM-stage instruction accesses data memory.
mem_ready  in  1  data memory completes the access this cycle.
freeze_pc  out  1  hold the PC.
freeze_if_id  out  1  hold the IF/ID register.
flush_if_id  out  1  load a NOP into IF/ID.
bubble_id_exe  out  1  load a NOP into ID/EXE.
stall_all  out  1  hold PC and every pipeline register (ID/EXE, EXE/MEM, MEM/WB included).
mem_err  out  1  sticky memory-timeout flag.
stall_cnt  out  CNT_W  cycles with stall_all=1.
bubble_cnt  out  CNT_W  bubbles inserted due to hazards.
flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Register-zero rule: a register hazard match requires equal addresses, address != 0, and the write enable set.
  - src2_id is compared only when two_src_id=1.
- States: RUN and MEM_WAIT. An internal 12-bit wait counter wcnt tracks the wait.
- Memory stall (highest priority):
  - stall_all = (state==RUN && mem_req && !mem_ready) || (state==MEM_WAIT && !mem_ready).
  - Transitions:
    - RUN -> MEM_WAIT when mem_req && !mem_ready.
    - MEM_WAIT -> RUN when mem_ready.
    - mem_ready in the same cycle as mem_req gives zero stall.
  - wcnt is cleared on entry to MEM_WAIT and incremented each cycle in MEM_WAIT while !mem_ready, saturating at its maximum.
  - When wcnt reaches MEM_TIMEOUT, mem_err sets and stays set until rst. The FSM keeps waiting; it never aborts the access.
  - While stall_all=1, freeze_pc, freeze_if_id, flush_if_id and bubble_id_exe are all 0.
- Branch (second priority, only when stall_all=0):
  - branch_taken_exe=1 drives flush_if_id=1 and bubble_id_exe=1, and drives freeze_pc=0 and freeze_if_id=0.
  - Any simultaneous ID hazard is ignored, because the ID instruction is squashed.
  - flush_cnt increments once per such cycle.
- Hazard (third priority): with hazard=1, drive freeze_pc=1, freeze_if_id=1 and bubble_id_exe=1. bubble_cnt increments.
  - With forwarding, hazard = load-use only: mem_r_en_exe && wb_en_exe && dst_exe matches a used source.
  - A load stalls exactly 1 cycle. The following cycle the load is in MEM and forwarding resolves the dependency.
- Combinational outputs: freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe and stall_all are combinational from the inputs and state. All are forced to 0 while rst=1.
- Counters:
  - stall_cnt increments on every stall_all cycle.
  - All counters saturate at 2^CNT_W-1; they do not wrap.
  - All counters are registered.
- Reset (rst=1 at a clock edge): state=RUN, wcnt=0, mem_err=0, all counters=0.
  - Reset during MEM_WAIT abandons the wait; the next cycle is RUN.

Optional Feature:
FORWARDING_EN
- Defined: the hazard term is load-use only, as above.
- Undefined (no forwarding unit present): hazard = any used source matching dst_exe (with wb_en_exe) or dst_mem (with wb_en_mem), load or not.
  - A dependent instruction therefore stalls until the producer reaches WB.
  - A dependency on dst_exe gives 2 bubbles; a dependency on dst_mem gives 1 bubble.
- Priority, memory-stall and counter behaviour are identical in both builds.

Test Plan:
- Load-use: EXE load dst_exe=5, ID src1_id=5. -> freeze_pc=freeze_if_id=bubble_id_exe=1 for exactly 1 cycle; bubble_cnt=1. Same case with src1_id=0 and dst_exe=0 -> no stall.
- ALU dependency: wb_en_exe=1, mem_r_en_exe=0, dst_exe=7, src2_id=7, two_src_id=1. -> FORWARDING_EN: no stall. Undefined: 2 bubble cycles, then release. Same with two_src_id=0 -> no stall in either build.
- Branch overrides hazard: branch_taken_exe=1 with a load-use match present. -> flush_if_id=1, bubble_id_exe=1, freeze_pc=0; flush_cnt=1, bubble_cnt=0.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high. -> stall_all=1 for 3 cycles, state returns to RUN, stall_cnt=3. A pending branch_taken_exe is only acted on after the stall ends.
- Timeout: MEM_TIMEOUT=4, mem_ready held low for 10 cycles. -> mem_err=1 after the 4th MEM_WAIT cycle; it stays 1 after mem_ready and clears only on rst.
- Reset mid-wait: rst pulsed during MEM_WAIT. -> next cycle state=RUN, counters=0, mem_err=0, all control outputs 0 while rst=1.
